pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 145 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Debug-link sequencer: loads instruction memory from a byte stream, then runs or single-steps the pipeline.
// Every output is registered, one cycle after the input that caused it. No backpressure: bytes are one-cycle strobes.
module pipeline_sequencer #(
  parameter int          NBITS_ADDR = 10,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_Cmd,
  input  logic                  i_CmdValid,
  input  logic                  i_Halt,
  output logic                  o_PipeEnable,
  output logic                  o_PipeReset,
  output logic                  o_InstrWrEn,
  output logic [NBITS_ADDR-1:0] o_InstrWrAddr,
  output logic [31:0]           o_InstrWrData,
  output logic [2:0]            o_State,
  output logic [31:0]           o_CycleCount
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_CLEAR = 8'h43;

  state_t                state_q, state_d;
  logic                  pipe_en_q, pipe_en_d;
  logic                  pipe_rst_q, pipe_rst_d;
  logic                  wr_en_q, wr_en_d;
  logic [NBITS_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [NBITS_ADDR-1:0] load_addr_q, load_addr_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [31:0]           cycle_cnt_q, cycle_cnt_d;
  logic [31:0]           word;

  always_comb begin
    state_d     = state_q;
    pipe_rst_d  = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    load_addr_d = load_addr_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    cycle_cnt_d = cycle_cnt_q + {31'd0, pipe_en_q};
    word        = {shift_q, i_Cmd};

    case (state_q)
      ST_IDLE: begin
        if (i_CmdValid) begin
          case (i_Cmd)
            CMD_LOAD: begin
              state_d     = ST_LOAD;
              byte_cnt_d  = 2'd0;
              load_addr_d = '0;
              cycle_cnt_d = 32'd0;
            end
            CMD_RUN:   state_d = ST_RUN;
            CMD_STEP:  state_d = ST_STEP;
            CMD_CLEAR: begin
              pipe_rst_d  = 1'b1;
              cycle_cnt_d = 32'd0;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (i_CmdValid) begin
          shift_d    = word[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d     = 1'b1;
            wr_data_d   = word;
            wr_addr_d   = load_addr_q;
            load_addr_d = load_addr_q + NBITS_ADDR'(1);
            // The last address ends the load rather than wrapping onto word 0.
            if (word == HALT_WORD || load_addr_q == '1)
              state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        if (i_Halt)
          state_d = ST_DONE;
      end
      ST_STEP: state_d = i_Halt ? ST_DONE : ST_IDLE;
      ST_DONE: begin
        if (i_CmdValid && i_Cmd == CMD_CLEAR) begin
          state_d     = ST_IDLE;
          pipe_rst_d  = 1'b1;
          cycle_cnt_d = 32'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pipe_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      pipe_en_q   <= 1'b0;
      pipe_rst_q  <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 32'd0;
      load_addr_q <= '0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      cycle_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pipe_en_q   <= pipe_en_d;
      pipe_rst_q  <= pipe_rst_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      load_addr_q <= load_addr_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign o_PipeEnable  = pipe_en_q;
  assign o_PipeReset   = pipe_rst_q;
  assign o_InstrWrEn   = wr_en_q;
  assign o_InstrWrAddr = wr_addr_q;
  assign o_InstrWrData = wr_data_q;
  assign o_State       = state_q;
  assign o_CycleCount  = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: a default instance plus a 2-bit-address instance for the no-wrap load.
module tb_pipeline_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd;
  logic       vld;
  logic       halt;
  logic       sel;

  logic        a_en, a_prst, a_wr;
  logic [9:0]  a_addr;
  logic [31:0] a_data, a_cnt;
  logic [2:0]  a_st;
  logic        b_en, b_prst, b_wr;
  logic [1:0]  b_addr;
  logic [31:0] b_data, b_cnt;
  logic [2:0]  b_st;

  logic        m_en, m_prst, m_wr;
  logic [9:0]  m_addr;
  logic [31:0] m_data, m_cnt;
  logic [2:0]  m_st;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [9:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int len; logic [31:0] cnt; logic [2:0] st; } run_t;
  wr_t  wq[$];
  run_t rq[$];
  int   pq[$];

  always #5 clk = ~clk;

  pipeline_sequencer #(.NBITS_ADDR(10)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_Cmd(cmd), .i_CmdValid(vld & ~sel), .i_Halt(halt & ~sel),
    .o_PipeEnable(a_en), .o_PipeReset(a_prst), .o_InstrWrEn(a_wr), .o_InstrWrAddr(a_addr),
    .o_InstrWrData(a_data), .o_State(a_st), .o_CycleCount(a_cnt)
  );

  pipeline_sequencer #(.NBITS_ADDR(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_Cmd(cmd), .i_CmdValid(vld & sel), .i_Halt(halt & sel),
    .o_PipeEnable(b_en), .o_PipeReset(b_prst), .o_InstrWrEn(b_wr), .o_InstrWrAddr(b_addr),
    .o_InstrWrData(b_data), .o_State(b_st), .o_CycleCount(b_cnt)
  );

  assign m_en   = sel ? b_en   : a_en;
  assign m_prst = sel ? b_prst : a_prst;
  assign m_wr   = sel ? b_wr   : a_wr;
  assign m_addr = sel ? {8'd0, b_addr} : a_addr;
  assign m_data = sel ? b_data : a_data;
  assign m_st   = sel ? b_st   : a_st;
  assign m_cnt  = sel ? b_cnt  : a_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: write pulses, enable bursts and pipe-reset pulses each pop their own queue.
  int   run_len  = 0;
  logic prev_rst = 1'b0;
  always @(negedge clk) begin
    wr_t  w;
    run_t r;
    if (m_wr === 1'b1) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        w = wq.pop_front();
        check("wr_addr", {22'd0, m_addr}, {22'd0, w.addr});
        check("wr_data", m_data, w.data);
        check("wr_with_pipe_en", {31'd0, m_en}, 32'd0);
      end
    end
    if (m_en === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      if (rq.size() == 0) begin
        check("unexpected_enable_burst", 32'd1, 32'd0);
      end else begin
        r = rq.pop_front();
        check("enable_len", run_len, r.len);
        check("cycle_count_after_burst", m_cnt, r.cnt);
        check("state_after_burst", {29'd0, m_st}, {29'd0, r.st});
      end
      run_len = 0;
    end
    if (m_prst === 1'b1 && !prev_rst) begin
      if (pq.size() == 0) begin
        check("unexpected_pipe_reset", 32'd1, 32'd0);
      end else begin
        void'(pq.pop_front());
        check("state_at_pipe_reset", {29'd0, m_st}, 32'd0);
        check("count_at_pipe_reset", m_cnt, 32'd0);
      end
    end
    prev_rst = (m_prst === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cmd = b;
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send(t[7:0]);
    end
  endtask

  task automatic do_reset();
    pq.push_back(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    cmd  = 8'h00;
    vld  = 1'b0;
    halt = 1'b0;
    sel  = 1'b0;

    do_reset();
    check("reset_state", {29'd0, a_st}, 32'd0);
    check("reset_pipe_en", {31'd0, a_en}, 32'd0);
    check("reset_pipe_rst", {31'd0, a_prst}, 32'd1);
    check("reset_wr_en", {31'd0, a_wr}, 32'd0);
    check("reset_wr_addr", {22'd0, a_addr}, 32'd0);
    check("reset_wr_data", a_data, 32'd0);
    check("reset_count", a_cnt, 32'd0);
    tick();

    // Two-word load terminated by HALT
    send(8'h4C);
    check("load_entry_state", {29'd0, a_st}, 32'd1);
    wq.push_back('{10'd0, 32'h2001_0005});
    wq.push_back('{10'd1, 32'hFFFF_FFFF});
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    check("state_after_halt_word", {29'd0, a_st}, 32'd0);
    tick();

    // Free run, halt in the eighth enabled cycle
    rq.push_back('{8, 32'd8, 3'd4});
    send(8'h52);
    repeat (7) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("run_done_state", {29'd0, a_st}, 32'd4);
    check("run_done_count", a_cnt, 32'd8);
    send(8'h52);
    send(8'h4C);
    check("done_ignores_cmds", {29'd0, a_st}, 32'd4);
    pq.push_back(1);
    send(8'h43);
    tick();

    // Three isolated single steps
    for (int i = 1; i <= 3; i++) begin
      rq.push_back('{1, i, 3'd0});
      send(8'h53);
      tick();
    end
    check("step_count", a_cnt, 32'd3);

    // Halt and a clear byte together in RUN
    rq.push_back('{1, 32'd4, 3'd4});
    send(8'h52);
    cmd  = 8'h43;
    vld  = 1'b1;
    halt = 1'b1;
    tick();
    vld  = 1'b0;
    halt = 1'b0;
    check("halt_priority_state", {29'd0, a_st}, 32'd4);
    check("halt_priority_count", a_cnt, 32'd4);
    pq.push_back(1);
    send(8'h43);

    // Halt ignored in IDLE; clear in IDLE pulses pipe reset
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("idle_ignores_halt", {29'd0, a_st}, 32'd0);
    pq.push_back(1);
    send(8'h43);
    tick();

    // Step that sees halt goes to DONE
    rq.push_back('{1, 32'd1, 3'd4});
    send(8'h53);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("step_halt_state", {29'd0, a_st}, 32'd4);
    pq.push_back(1);
    send(8'h43);

    // Reset mid-word discards it; next load restarts at address 0
    send(8'h4C);
    send(8'hAA);
    send(8'hBB);
    do_reset();
    check("midload_reset_state", {29'd0, a_st}, 32'd0);
    tick();
    send(8'h4C);
    wq.push_back('{10'd0, 32'h1234_5678});
    send_word(32'h1234_5678);
    check("load_continues", {29'd0, a_st}, 32'd1);
    tick();

    // Small-address instance: load stops after the last address
    sel = 1'b1;
    tick();
    send(8'h4C);
    wq.push_back('{10'd0, 32'h0102_0405});
    wq.push_back('{10'd1, 32'h1112_1415});
    wq.push_back('{10'd2, 32'h2122_2425});
    wq.push_back('{10'd3, 32'h3132_3435});
    send_word(32'h0102_0405);
    send_word(32'h1112_1415);
    send_word(32'h2122_2425);
    send_word(32'h3132_3435);
    check("noload_wrap_state", {29'd0, b_st}, 32'd0);
    send_word(32'h4142_4445);
    check("fifth_word_ignored_state", {29'd0, b_st}, 32'd0);
    check("fifth_word_count", b_cnt, 32'd0);
    repeat (3) tick();

    check("writes_outstanding", wq.size(), 32'd0);
    check("bursts_outstanding", rq.size(), 32'd0);
    check("pipe_resets_outstanding", pq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
